mig_tt_sequencer: RTL and testbench

Sequential evaluator for 4-input majority-inverter graphs (MIGs) of the kind our exact-synthesis netlists describe.
- A small node program is loaded through a write port.
- One shared bit-parallel MAJ3 unit evaluates one node per cycle over all 16 input minterms at once.
- The result is the function's 16-bit truth table.
- Used to check and characterise NPN-class MIG implementations in hardware, without instantiating a combinational copy of each one.

---
 rtl/mig_tt_sequencer_pkg.sv | 41 ++++
 rtl/mig_tt_sequencer_if.sv | 27 ++
 rtl/mig_maj3_vec.sv | 19 +
 rtl/mig_tt_sequencer.sv | 142 ++++++++++++++
 tb/tb_mig_tt_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mig_tt_sequencer_pkg.sv
// Shared constants and types for the MIG truth-table sequencer.
package mig_tt_pkg;

    localparam logic [3:0] SEL_CONST0    = 4'd0;
    localparam logic [3:0] SEL_X0        = 4'd1;
    localparam logic [3:0] SEL_X1        = 4'd2;
    localparam logic [3:0] SEL_X2        = 4'd3;
    localparam logic [3:0] SEL_X3        = 4'd4;
    localparam logic [3:0] SEL_NODE_BASE = 4'd5;

    localparam logic [15:0] TT_X0 = 16'hAAAA;
    localparam logic [15:0] TT_X1 = 16'hCCCC;
    localparam logic [15:0] TT_X2 = 16'hF0F0;
    localparam logic [15:0] TT_X3 = 16'hFF00;

    // Each operand is a 5-bit {c, sel} slice of the 15-bit node word.
    localparam int OFF_A = 10;
    localparam int OFF_B = 5;
    localparam int OFF_C = 0;

    typedef enum logic [1:0] {IDLE, EVAL, FINISH} state_t;

    typedef struct packed {
        logic       c;
        logic [3:0] sel;
    } opnd_t;

    function automatic logic [15:0] proj(input logic [3:0] sel);
        logic [15:0] v;
        v = 16'h0000;
        unique case (sel)
            SEL_X0:  v = TT_X0;
            SEL_X1:  v = TT_X1;
            SEL_X2:  v = TT_X2;
            SEL_X3:  v = TT_X3;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mig_tt_sequencer_if.sv
// Program-load and run-control bundle of the MIG sequencer.
interface mig_tt_sequencer_if;

    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [14:0] prog_data;
    logic [3:0]  num_nodes;
    logic [4:0]  out_sel;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] tt;

    modport master (
        output prog_we, prog_addr, prog_data,
        output num_nodes, out_sel, start,
        input  busy, done, err, tt
    );

    modport slave (
        input  prog_we, prog_addr, prog_data,
        input  num_nodes, out_sel, start,
        output busy, done, err, tt
    );

endinterface

// File: rtl/mig_maj3_vec.sv
// Bit-parallel 16-lane majority with per-operand complement.
module mig_maj3_vec (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic        ca,
    input  logic        cb,
    input  logic        cc,
    output logic [15:0] y
);

    logic [15:0] ra, rb, rc;

    assign ra = a ^ {16{ca}};
    assign rb = b ^ {16{cb}};
    assign rc = c ^ {16{cc}};
    assign y  = (ra & rb) | (ra & rc) | (rb & rc);

endmodule

// File: rtl/mig_tt_sequencer.sv
// Evaluates a loaded MIG program one node per cycle into a 16-bit truth table.
module mig_tt_sequencer
    import mig_tt_pkg::*;
#(
    parameter int MAX_NODES = 8,
    parameter int SEL_W     = 4
) (
    input logic              clk,
    input logic              rst_n,
    mig_tt_sequencer_if.slave bus
);

    localparam int IW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam int LW = SEL_W + 1;

    logic [14:0] prog [MAX_NODES];
    logic [15:0] res  [MAX_NODES];

    state_t      state;
    logic [3:0]  idx;
    logic [3:0]  n_lat;
    opnd_t       osel;
    logic        busy, done, err;
    logic [15:0] tt;

    logic [14:0]   word;
    opnd_t         op_a, op_b, op_c, in_osel;
    logic [15:0]   va, vb, vc, nv, ov, iv;
    logic [LW-1:0] lim, olim;
    logic          legal, last, o_ok, o_byp;
    logic          prog_wr, res_wr;

    function automatic logic [15:0] pick(input logic [3:0] s);
        if (s < SEL_NODE_BASE) return proj(s);
        return res[IW'(s - SEL_NODE_BASE)];
    endfunction

    always_comb begin
        word    = prog[IW'(idx)];
        op_a    = opnd_t'(word[OFF_A +: 5]);
        op_b    = opnd_t'(word[OFF_B +: 5]);
        op_c    = opnd_t'(word[OFF_C +: 5]);
        in_osel = opnd_t'(bus.out_sel);
        lim     = LW'(idx) + LW'(SEL_NODE_BASE);
        legal   = ({1'b0, op_a.sel} < lim)
                && ({1'b0, op_b.sel} < lim)
                && ({1'b0, op_c.sel} < lim);
        va      = pick(op_a.sel);
        vb      = pick(op_b.sel);
        vc      = pick(op_c.sel);
        last    = (idx == n_lat - 4'd1);
        olim    = LW'(n_lat) + LW'(SEL_NODE_BASE);
        o_ok    = {1'b0, osel.sel} < olim;
        // The last node is written this cycle, so forward it to the output.
        o_byp   = {1'b0, osel.sel} == lim;
        ov      = (o_byp ? nv : pick(osel.sel)) ^ {16{osel.c}};
        iv      = proj(in_osel.sel) ^ {16{in_osel.c}};
    end

    mig_maj3_vec u_maj (
        .a  (va),
        .b  (vb),
        .c  (vc),
        .ca (op_a.c),
        .cb (op_b.c),
        .cc (op_c.c),
        .y  (nv)
    );

    assign prog_wr = (state == IDLE) && bus.prog_we
                   && (int'(bus.prog_addr) < MAX_NODES);
    assign res_wr  = (state == EVAL) && legal;

    always_ff @(posedge clk) begin
        if (prog_wr) prog[IW'(bus.prog_addr)] <= bus.prog_data;
        if (res_wr)  res[IW'(idx)] <= nv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            n_lat <= '0;
            osel  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            tt    <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_lat <= bus.num_nodes;
                        osel  <= in_osel;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        idx   <= '0;
                        if (int'(bus.num_nodes) > MAX_NODES) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else if (bus.num_nodes == 4'd0) begin
                            if (in_osel.sel < SEL_NODE_BASE) tt <= iv;
                            else err <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            state <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    if (!legal) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else if (last) begin
                        if (o_ok) tt <= ov;
                        else err <= 1'b1;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err  = err;
    assign bus.tt   = tt;

endmodule

// File: tb/tb_mig_tt_sequencer.sv
// Directed self-checking bench for mig_tt_sequencer.
module tb_mig_tt_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat;

    always #5 clk = ~clk;

    mig_tt_sequencer_if bus ();

    mig_tt_sequencer #(.MAX_NODES(8), .SEL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [14:0] nd(
        input logic ca, input logic [3:0] sa,
        input logic cb, input logic [3:0] sb,
        input logic cc, input logic [3:0] sc);
        return {ca, sa, cb, sb, cc, sc};
    endfunction

    function automatic logic [4:0] os(input logic c, input logic [3:0] s);
        return {c, s};
    endfunction

    task automatic wr(input logic [2:0] a, input logic [14:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic wait_done(inout int l);
        while (bus.done !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input logic [3:0] n, input logic [4:0] o,
                       output int l);
        bus.num_nodes = n;
        bus.out_sel   = o;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        l = 1;
        wait_done(l);
        @(negedge clk);
    endtask

    initial begin
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.num_nodes = '0;
        bus.out_sel   = '0;
        bus.start     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_tt", bus.tt, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        wr(0, nd(0, 1, 0, 2, 0, 3));
        run(1, os(0, 5), lat);
        chk("maj_lat", lat, 2);
        chk("maj_tt", bus.tt, 16'hE8E8);
        chk("maj_err", bus.err, 0);
        chk("maj_busy", bus.busy, 0);

        wr(0, nd(0, 1, 0, 2, 0, 0));
        run(1, os(1, 5), lat);
        chk("nand_tt", bus.tt, 16'h7777);
        run(1, os(0, 5), lat);
        chk("and_tt", bus.tt, 16'h8888);
        wr(0, nd(0, 1, 0, 2, 1, 0));
        run(1, os(0, 5), lat);
        chk("or_tt", bus.tt, 16'hEEEE);

        // XOR; node 2 is written in the same cycle as start.
        wr(0, nd(0, 1, 0, 2, 0, 0));
        wr(1, nd(0, 1, 0, 2, 1, 0));
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd2;
        bus.prog_data = nd(1, 5, 0, 6, 0, 0);
        bus.num_nodes = 4'd3;
        bus.out_sel   = os(0, 7);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.prog_we = 1'b0;
        bus.start   = 1'b0;
        lat = 1;
        chk("xor_busy", bus.busy, 1);
        wait_done(lat);
        @(negedge clk);
        chk("xor_lat", lat, 4);
        chk("xor_tt", bus.tt, 16'h6666);

        run(0, os(0, 4), lat);
        chk("zero_lat", lat, 1);
        chk("zero_tt", bus.tt, 16'hFF00);
        chk("zero_err", bus.err, 0);

        wr(0, nd(0, 6, 0, 1, 0, 2));
        run(2, os(0, 5), lat);
        chk("fwd_lat", lat, 2);
        chk("fwd_err", bus.err, 1);
        chk("fwd_tt", bus.tt, 16'hFF00);

        run(12, os(0, 1), lat);
        chk("big_lat", lat, 1);
        chk("big_err", bus.err, 1);
        chk("big_tt", bus.tt, 16'hFF00);

        wr(0, nd(0, 1, 0, 2, 0, 0));
        run(1, os(0, 5), lat);
        chk("clr_err", bus.err, 0);
        chk("clr_tt", bus.tt, 16'h8888);

        run(1, os(0, 6), lat);
        chk("osel_lat", lat, 2);
        chk("osel_err", bus.err, 1);
        chk("osel_tt", bus.tt, 16'h8888);

        run(0, os(1, 3), lat);
        chk("inv_x2_tt", bus.tt, 16'h0F0F);
        chk("inv_x2_err", bus.err, 0);

        // Start and write while busy must not disturb the run.
        bus.num_nodes = 4'd3;
        bus.out_sel   = os(0, 7);
        bus.start     = 1'b1;
        @(negedge clk);
        lat = 1;
        bus.num_nodes = 4'd0;
        bus.out_sel   = os(0, 1);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd1;
        bus.prog_data = nd(0, 1, 0, 2, 0, 0);
        @(negedge clk);
        lat = 2;
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        chk("busy_nodone", bus.done, 0);
        wait_done(lat);
        @(negedge clk);
        chk("busy_lat", lat, 4);
        chk("busy_tt", bus.tt, 16'h6666);
        run(2, os(0, 6), lat);
        chk("busy_prog", bus.tt, 16'hEEEE);

        bus.num_nodes = 4'd3;
        bus.out_sel   = os(0, 7);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_tt", bus.tt, 16'h0000);
        chk("mrst_err", bus.err, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_nodone", bus.done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run(0, os(0, 1), lat);
        chk("post_lat", lat, 1);
        chk("post_tt", bus.tt, 16'hAAAA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
